alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 4-bit combinational ALU: WIDTH-bit operands, 8 opcodes and a full flag set (zero, carry, negative, overflow).
- Valid/ready handshake on input and output, with a one-entry registered output.
- Single-cycle ops have 1-cycle latency. Logical shifts run iteratively, one bit per cycle, under a small FSM.
- Sits between an operand-issue stage and a writeback stage.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 83 ++++++++
 rtl/alu_pipe.sv | 142 ++++++++++++++
 tb/tb_alu_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings, FSM state
// encoding and bit positions inside the registered flag vector.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_SRL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational datapath for the single-cycle ALU operations.
// Produces result, carry/borrow and signed overflow. Shift opcodes fall
// through to "result = a, carry = 0", which is exactly the amount-0 shift.
// Optional macro ALU_SAT_EN: unsigned saturation of ADD/SUB results.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH:0]          sum_ext;
  logic [WIDTH:0]          dif_ext;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] sum_s;
  logic signed [WIDTH-1:0] dif_s;
  logic                    ovf_add;
  logic                    ovf_sub;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign dif_ext = {1'b0, a} - {1'b0, b};
  assign a_s     = $signed(a);
  assign b_s     = $signed(b);
  assign sum_s   = $signed(sum_ext[WIDTH-1:0]);
  assign dif_s   = $signed(dif_ext[WIDTH-1:0]);

  // Two's-complement overflow: operands agree (ADD) or differ (SUB) in sign
  // and the result sign differs from a.
  assign ovf_add = ((a_s < 0) == (b_s < 0)) && ((sum_s < 0) != (a_s < 0));
  assign ovf_sub = ((a_s < 0) != (b_s < 0)) && ((dif_s < 0) != (a_s < 0));

`ifdef ALU_SAT_EN
  // Clamp to all ones on unsigned carry-out.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH:0] s);
    return s[WIDTH] ? '1 : s[WIDTH-1:0];
  endfunction

  // Clamp to zero on unsigned borrow.
  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH:0] d);
    return d[WIDTH] ? '0 : d[WIDTH-1:0];
  endfunction
`endif

  // Operation select; carry always reports the raw carry/borrow.
  always_comb begin
    res   = a;
    carry = 1'b0;
    ovf   = 1'b0;
    case (opcode)
      OP_ADD: begin
`ifdef ALU_SAT_EN
        res = sat_add(sum_ext);
`else
        res = sum_ext[WIDTH-1:0];
`endif
        carry = sum_ext[WIDTH];
        ovf   = ovf_add;
      end
      OP_SUB: begin
`ifdef ALU_SAT_EN
        res = sat_sub(dif_ext);
`else
        res = dif_ext[WIDTH-1:0];
`endif
        carry = dif_ext[WIDTH];
        ovf   = ovf_sub;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_PASS: res = a;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake and a one-entry output register.
// Single-cycle ops complete with latency 1; SLL/SRL iterate one bit per
// cycle under a two-state FSM and complete N+1 cycles after accept.
// Optional macro ALU_SAT_EN (handled in alu_core): saturating ADD/SUB.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             neg_flag,
  output logic             ovf_flag
);

  state_t           state_p1;
  logic [WIDTH-1:0] sh_val_p1;
  logic [SHW-1:0]   sh_cnt_p1;
  logic             sh_left_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] result_p1;
  logic [3:0]       flags_p1;

  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_ovf;
  logic [SHW-1:0]   amt;
  logic             is_shift;
  logic             accept;
  logic             start_shift;
  logic             load_now;
  logic             shift_last;
  logic [WIDTH-1:0] sh_next;
  logic             sh_bit;
  logic [WIDTH-1:0] ld_res;
  logic             ld_carry;
  logic             ld_ovf;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .res    (core_res),
    .carry  (core_carry),
    .ovf    (core_ovf)
  );

  assign amt         = b[SHW-1:0];
  assign is_shift    = (opcode == OP_SLL) || (opcode == OP_SRL);
  assign in_ready    = !rst && (state_p1 == ST_IDLE) && (!vld_p1 || out_ready);
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift && (amt != '0);
  assign load_now    = accept && !start_shift;
  assign shift_last  = (state_p1 == ST_SHIFT) && (sh_cnt_p1 == SHW'(1));

  // One-bit shift step and the bit it pushes out.
  always_comb begin
    if (sh_left_p1) begin
      sh_next = {sh_val_p1[WIDTH-2:0], 1'b0};
      sh_bit  = sh_val_p1[WIDTH-1];
    end else begin
      sh_next = {1'b0, sh_val_p1[WIDTH-1:1]};
      sh_bit  = sh_val_p1[0];
    end
  end

  // Select what the output register captures: final shift step or core result.
  always_comb begin
    ld_res   = core_res;
    ld_carry = core_carry;
    ld_ovf   = core_ovf;
    if (shift_last) begin
      ld_res   = sh_next;
      ld_carry = sh_bit;
      ld_ovf   = 1'b0;
    end
  end

  // ---- stage p1: FSM ----
  // Control FSM: IDLE accepts work, SHIFT runs the iterative shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ST_IDLE;
    end else begin
      case (state_p1)
        ST_IDLE:  if (start_shift) state_p1 <= ST_SHIFT;
        ST_SHIFT: if (shift_last)  state_p1 <= ST_IDLE;
        default:  state_p1 <= ST_IDLE;
      endcase
    end
  end

  // Shifter working registers; only meaningful while state is SHIFT.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_val_p1  <= a;
      sh_cnt_p1  <= amt;
      sh_left_p1 <= (opcode == OP_SLL);
    end else if (state_p1 == ST_SHIFT) begin
      sh_val_p1 <= sh_next;
      sh_cnt_p1 <= sh_cnt_p1 - SHW'(1);
    end
  end

  // ---- stage p1: output register ----
  // One-entry output buffer: load on completion, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      flags_p1  <= '0;
    end else if (load_now || shift_last) begin
      vld_p1          <= 1'b1;
      result_p1       <= ld_res;
      flags_p1[FLG_Z] <= (ld_res == '0);
      flags_p1[FLG_C] <= ld_carry;
      flags_p1[FLG_N] <= ld_res[WIDTH-1];
      flags_p1[FLG_V] <= ld_ovf;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign result     = result_p1;
  assign zero_flag  = flags_p1[FLG_Z];
  assign carry_flag = flags_p1[FLG_C];
  assign neg_flag   = flags_p1[FLG_N];
  assign ovf_flag   = flags_p1[FLG_V];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe (WIDTH=8). Expected values are hand
// computed; the saturation vectors follow ALU_SAT_EN if it is defined.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero_flag;
  logic       carry_flag;
  logic       neg_flag;
  logic       ovf_flag;

  int vectors     = 0;
  int miscompares = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .neg_flag   (neg_flag),
    .ovf_flag   (ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one cycle (caller ensures in_ready).
  task automatic issue(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    opcode   = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a        = 8'hEE;
    b        = 8'hEE;
    opcode   = 3'b000;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] r,
                         input logic z, input logic c, input logic n, input logic v);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".result"}, {24'd0, result}, {24'd0, r});
    chk({tag, ".zero"}, {31'd0, zero_flag}, {31'd0, z});
    chk({tag, ".carry"}, {31'd0, carry_flag}, {31'd0, c});
    chk({tag, ".neg"}, {31'd0, neg_flag}, {31'd0, n});
    chk({tag, ".ovf"}, {31'd0, ovf_flag}, {31'd0, v});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    opcode    = '0;
    step();
    step();
    // Reset state
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.result", {24'd0, result}, 32'd0);
    chk("rst.flags", {28'd0, zero_flag, carry_flag, neg_flag, ovf_flag}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle.in_ready", {31'd0, in_ready}, 32'd1);

    // ADD 200+100 = 300 -> 44, carry
    issue(3'b000, 8'd200, 8'd100);
    chk_out("add", 8'd44, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("add.drain", {31'd0, out_valid}, 32'd0);

    // SUB 5-5 -> 0
    issue(3'b001, 8'd5, 8'd5);
    chk_out("sub_eq", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    // SUB 0x80-1 -> 0x7F signed overflow (back-to-back accept)
    issue(3'b001, 8'h80, 8'h01);
    chk_out("sub_ovf", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    // ADD 0x7F+1 -> 0x80 signed overflow, negative
    issue(3'b000, 8'h7F, 8'h01);
    chk_out("add_ovf", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    // Logical ops
    issue(3'b010, 8'hCC, 8'hAA);
    chk_out("and", 8'h88, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(3'b011, 8'h0C, 8'h30);
    chk_out("or", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 8'hA5, 8'h00);
    chk_out("pass", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    step();

    // SLL 0x81 by 3: 3 busy cycles, result 0x08 carry 0
    issue(3'b101, 8'h81, 8'd3);
    chk("sll.busy1", {30'd0, in_ready, out_valid}, 32'd0);
    step();
    chk("sll.busy2", {30'd0, in_ready, out_valid}, 32'd0);
    step();
    chk("sll.busy3", {30'd0, in_ready, out_valid}, 32'd0);
    step();
    chk_out("sll", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sll.ready", {31'd0, in_ready}, 32'd1);
    step();

    // SRL 0x81 by 1: latency 2, result 0x40 carry 1
    issue(3'b110, 8'h81, 8'd1);
    chk("srl.busy", {30'd0, in_ready, out_valid}, 32'd0);
    step();
    chk_out("srl", 8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    step();

    // Shift amount taken from b[2:0] only: b=8 -> amount 0, latency 1
    issue(3'b101, 8'h5A, 8'h08);
    chk_out("sll0", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    // SRL by 7 (maximum): 0x80 -> 0x01, last bit out 0
    issue(3'b110, 8'h80, 8'd7);
    for (int i = 0; i < 6; i++) step();
    chk("srl7.early", {31'd0, out_valid}, 32'd0);
    step();
    chk_out("srl7", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Backpressure: result held, in_ready low
    out_ready = 1'b0;
    issue(3'b000, 8'd1, 8'd2);
    chk_out("bp0", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp0.in_ready", {31'd0, in_ready}, 32'd0);
    a = 8'h77; b = 8'h11; opcode = 3'b100; // ignored while not accepted
    step();
    chk_out("bp1", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp1.in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk_out("bp2", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    opcode    = 3'b100;
    a         = 8'hF0;
    b         = 8'hFF;
    in_valid  = 1'b1;
    #1;
    chk("bp.release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_out("bp.xor", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp.drain", {31'd0, out_valid}, 32'd0);

    // Reset during SHIFT abandons the operation
    issue(3'b101, 8'h01, 8'd7);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rmid.in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("rmid.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rmid.result", {24'd0, result}, 32'd0);
    chk("rmid.flags", {28'd0, zero_flag, carry_flag, neg_flag, ovf_flag}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rmid.ready_after", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) step();
    chk("rmid.no_result", {31'd0, out_valid}, 32'd0);
    issue(3'b000, 8'h10, 8'h20);
    chk_out("rmid.add", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation vectors
`ifdef ALU_SAT_EN
    issue(3'b000, 8'd250, 8'd10);
    chk_out("sat_add", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    issue(3'b001, 8'd3, 8'd9);
    chk_out("sat_sub", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    issue(3'b000, 8'd250, 8'd10);
    chk_out("wrap_add", 8'h04, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(3'b001, 8'd3, 8'd9);
    chk_out("wrap_sub", 8'hFA, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
    step();
    chk("final.drain", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
